// File: rtl/event_encoder_8x3_pkg.sv
// Shared definitions for the 8-line event encoder: widths, FSM states, one-hot helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package event_encoder_8x3_pkg;

  localparam int IDX_W = 3;
  localparam int LINES = 8;

  // Output register state: IDLE means valid=0, HOLD means a code is presented.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Expand a line index into a single-bit mask over all lines.
  function automatic logic [LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [LINES-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/event_encoder_8x3_if.sv
// Bundle of the encoder's request lines and its valid/ready code output.
// Ports: d (requests), ready (consumer accept) into the encoder; a, valid, pending, overrun out.
// Backpressure: ready is the only flow-control input; a/valid hold while ready=0.
interface event_encoder_8x3_if;
  import event_encoder_8x3_pkg::*;

  logic [LINES-1:0] d;
  logic             ready;
  logic [IDX_W-1:0] a;
  logic             valid;
  logic [LINES-1:0] pending;
  logic             overrun;

  // Encoder side.
  modport slave (
    input  d,
    input  ready,
    output a,
    output valid,
    output pending,
    output overrun
  );

  // Source/consumer side.
  modport master (
    output d,
    output ready,
    input  a,
    input  valid,
    input  pending,
    input  overrun
  );

endinterface

// File: rtl/event_encoder_8x3_prio_enc.sv
// Combinational 8-to-3 priority encoder (module prio_enc_8x3).
// Ports: i_req[7:0] in; o_idx[2:0] winning index, o_any = some request set. Latency: 0 cycles.
// Backpressure: n/a. With no request set, o_idx is 0 and o_any is 0.
module prio_enc_8x3
  import event_encoder_8x3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [LINES-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    // Later iterations overwrite earlier ones, so scan toward the winning end.
    if (HIGH_FIRST) begin
      for (int i = 0; i < LINES; i++) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end else begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder_8x3.sv
// Captures events on 8 request lines and presents one pending event per transfer as a 3-bit code.
// Ports: clk, reset_p (sync, active-high); bus = d/ready in, a/valid/pending/overrun out (all registered).
// Latency: d sampled at edge k -> pending after k -> valid/a after k+1; holds a/valid while ready=0.
module event_encoder_8x3
  import event_encoder_8x3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit EDGE_MODE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_p,
  event_encoder_8x3_if.slave   bus
);

  logic [LINES-1:0] r_d_prev;
  logic [LINES-1:0] r_pending;
  logic [IDX_W-1:0] r_a;
  logic             r_overrun;
  state_t           r_state;

  logic [LINES-1:0] w_rise;
  logic             w_accept;
  logic [LINES-1:0] w_clr;
  logic [LINES-1:0] w_nxt;
  logic [LINES-1:0] w_pending_nxt;
  logic             w_overrun_nxt;
  logic [IDX_W-1:0] w_pend_idx;
  logic             w_pend_any;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_any;
  logic [IDX_W-1:0] w_a_nxt;
  state_t           w_state_nxt;

  // Pick for the idle -> hold load.
  prio_enc_8x3 #(.HIGH_FIRST(HIGH_FIRST)) u_prio_pend (
    .i_req (r_pending),
    .o_idx (w_pend_idx),
    .o_any (w_pend_any)
  );

  // Pick for the back-to-back reload after an accept.
  prio_enc_8x3 #(.HIGH_FIRST(HIGH_FIRST)) u_prio_nxt (
    .i_req (w_nxt),
    .o_idx (w_nxt_idx),
    .o_any (w_nxt_any)
  );

  always_comb begin
    w_rise        = EDGE_MODE ? (bus.d & ~r_d_prev) : bus.d;
    w_accept      = (r_state == ST_HOLD) && bus.ready;
    w_clr         = w_accept ? onehot(r_a) : '0;
    // Reload candidates come from the registered pending set only; rises arriving
    // on the accept edge are seen one cycle later through r_pending.
    w_nxt         = r_pending & ~onehot(r_a);
    // Set wins over clear: a fresh rise on the bit being accepted re-arms it.
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    w_overrun_nxt = EDGE_MODE ? |(w_rise & r_pending & ~w_clr) : 1'b0;
  end

  // Output FSM next-state / code selection.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pend_any) begin
          w_a_nxt     = w_pend_idx;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_accept) begin
          if (w_nxt_any) begin
            w_a_nxt = w_nxt_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_d_prev  <= '0;
      r_pending <= '0;
      r_a       <= '0;
      r_overrun <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_d_prev  <= bus.d;
      r_pending <= w_pending_nxt;
      r_a       <= w_a_nxt;
      r_overrun <= w_overrun_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign bus.a       = r_a;
  assign bus.valid   = (r_state == ST_HOLD);
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Directed bench for event_encoder_8x3: high-first, low-first and level-mode instances share stimulus.
// Ports: none; drives clk/reset_p and the three interface instances.
// Outputs are sampled 1 time unit after each rising edge.
module tb_event_encoder_8x3;

  logic clk;
  logic reset_p;
  int   tests_run;
  int   tests_failed;

  event_encoder_8x3_if bus_hi ();
  event_encoder_8x3_if bus_lo ();
  event_encoder_8x3_if bus_lv ();

  event_encoder_8x3 #(.HIGH_FIRST(1'b1), .EDGE_MODE(1'b1)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus_hi)
  );

  event_encoder_8x3 #(.HIGH_FIRST(1'b0), .EDGE_MODE(1'b1)) dut_lo (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus_lo)
  );

  event_encoder_8x3 #(.HIGH_FIRST(1'b1), .EDGE_MODE(1'b0)) dut_lv (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus_lv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] dv, input logic rv);
    bus_hi.d = dv; bus_lo.d = dv; bus_lv.d = dv;
    bus_hi.ready = rv; bus_lo.ready = rv; bus_lv.ready = rv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    drive(8'h00, 1'b0);
    step();
    step();
    reset_p = 1'b0;
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    drive(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step();
    tests_run++; if (bus_hi.a !== 3'd0) begin tests_failed++; $display("FAIL reset_a: got %0d want 0", bus_hi.a); end
    tests_run++; if (bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", bus_hi.valid); end
    tests_run++; if (bus_hi.pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending: got %0h want 00", bus_hi.pending); end
    tests_run++; if (bus_hi.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0b want 0", bus_hi.overrun); end
    reset_p = 1'b0;
    step();
    tests_run++; if (bus_hi.pending !== 8'hFF) begin tests_failed++; $display("FAIL release_pending: got %0h want ff", bus_hi.pending); end
    tests_run++; if (bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL release_valid0: got %0b want 0", bus_hi.valid); end
    step();
    tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd7) begin tests_failed++; $display("FAIL release_code: got v=%0b a=%0d want v=1 a=7", bus_hi.valid, bus_hi.a); end
    tests_run++; if (bus_lo.valid !== 1'b1 || bus_lo.a !== 3'd0) begin tests_failed++; $display("FAIL release_code_lo: got v=%0b a=%0d want v=1 a=0", bus_lo.valid, bus_lo.a); end
  endtask

  task automatic test_single();
    do_reset();
    drive(8'h20, 1'b1);
    step();
    tests_run++; if (bus_hi.pending !== 8'h20 || bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL single_capture: got p=%0h v=%0b want p=20 v=0", bus_hi.pending, bus_hi.valid); end
    drive(8'h00, 1'b1);
    step();
    tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd5) begin tests_failed++; $display("FAIL single_present: got v=%0b a=%0d want v=1 a=5", bus_hi.valid, bus_hi.a); end
    step();
    tests_run++; if (bus_hi.valid !== 1'b0 || bus_hi.pending !== 8'h00) begin tests_failed++; $display("FAIL single_done: got v=%0b p=%0h want v=0 p=00", bus_hi.valid, bus_hi.pending); end
  endtask

  task automatic test_priority();
    logic [2:0] exp_hi [3];
    logic [2:0] exp_lo [3];
    exp_hi = '{3'd7, 3'd4, 3'd1};
    exp_lo = '{3'd1, 3'd4, 3'd7};
    do_reset();
    drive(8'h92, 1'b1);
    step();
    tests_run++; if (bus_hi.pending !== 8'h92) begin tests_failed++; $display("FAIL prio_pending: got %0h want 92", bus_hi.pending); end
    drive(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== exp_hi[i]) begin tests_failed++; $display("FAIL prio_hi_%0d: got v=%0b a=%0d want v=1 a=%0d", i, bus_hi.valid, bus_hi.a, exp_hi[i]); end
      tests_run++; if (bus_lo.valid !== 1'b1 || bus_lo.a !== exp_lo[i]) begin tests_failed++; $display("FAIL prio_lo_%0d: got v=%0b a=%0d want v=1 a=%0d", i, bus_lo.valid, bus_lo.a, exp_lo[i]); end
    end
    step();
    tests_run++; if (bus_hi.valid !== 1'b0 || bus_lo.valid !== 1'b0) begin tests_failed++; $display("FAIL prio_drained: got hi=%0b lo=%0b want 0 0", bus_hi.valid, bus_lo.valid); end
    tests_run++; if (bus_hi.pending !== 8'h00) begin tests_failed++; $display("FAIL prio_pending_empty: got %0h want 00", bus_hi.pending); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(8'h08, 1'b0);
    step();
    drive(8'h00, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive((i == 2) ? 8'h40 : 8'h00, 1'b0);
      step();
      tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd3) begin tests_failed++; $display("FAIL bp_hold_%0d: got v=%0b a=%0d want v=1 a=3", i, bus_hi.valid, bus_hi.a); end
    end
    tests_run++; if (bus_hi.pending !== 8'h48) begin tests_failed++; $display("FAIL bp_pending: got %0h want 48", bus_hi.pending); end
    drive(8'h00, 1'b1);
    step();
    tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd6) begin tests_failed++; $display("FAIL bp_next: got v=%0b a=%0d want v=1 a=6", bus_hi.valid, bus_hi.a); end
    step();
    tests_run++; if (bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL bp_done: got v=%0b want 0", bus_hi.valid); end
  endtask

  task automatic test_overrun();
    int deliveries;
    do_reset();
    drive(8'h04, 1'b0);
    step();
    tests_run++; if (bus_hi.overrun !== 1'b0 || bus_hi.pending !== 8'h04) begin tests_failed++; $display("FAIL ovr_first: got o=%0b p=%0h want o=0 p=04", bus_hi.overrun, bus_hi.pending); end
    drive(8'h00, 1'b0);
    step();
    drive(8'h04, 1'b0);
    step();
    tests_run++; if (bus_hi.overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_pulse: got %0b want 1", bus_hi.overrun); end
    step();
    tests_run++; if (bus_hi.overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_one_cycle: got %0b want 0", bus_hi.overrun); end
    deliveries = 0;
    drive(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (bus_hi.valid === 1'b1 && bus_hi.a === 3'd2) deliveries++;
      step();
    end
    tests_run++; if (deliveries != 1) begin tests_failed++; $display("FAIL ovr_once: got %0d deliveries want 1", deliveries); end
    tests_run++; if (bus_hi.pending !== 8'h00 || bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_drained: got p=%0h v=%0b want p=00 v=0", bus_hi.pending, bus_hi.valid); end
  endtask

  task automatic test_set_wins();
    do_reset();
    drive(8'h10, 1'b0);
    step();
    drive(8'h00, 1'b0);
    step();
    tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd4) begin tests_failed++; $display("FAIL sw_present: got v=%0b a=%0d want v=1 a=4", bus_hi.valid, bus_hi.a); end
    drive(8'h10, 1'b1);
    step();
    tests_run++; if (bus_hi.overrun !== 1'b0) begin tests_failed++; $display("FAIL sw_no_overrun: got %0b want 0", bus_hi.overrun); end
    tests_run++; if (bus_hi.pending !== 8'h10 || bus_hi.valid !== 1'b0) begin tests_failed++; $display("FAIL sw_rearmed: got p=%0h v=%0b want p=10 v=0", bus_hi.pending, bus_hi.valid); end
    step();
    tests_run++; if (bus_hi.valid !== 1'b1 || bus_hi.a !== 3'd4) begin tests_failed++; $display("FAIL sw_represent: got v=%0b a=%0d want v=1 a=4", bus_hi.valid, bus_hi.a); end
    step();
    tests_run++; if (bus_hi.valid !== 1'b0 || bus_hi.pending !== 8'h00) begin tests_failed++; $display("FAIL sw_done: got v=%0b p=%0h want v=0 p=00", bus_hi.valid, bus_hi.pending); end
    drive(8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(8'h81, 1'b0);
    step();
    step();
    drive(8'h00, 1'b1);
    reset_p = 1'b1;
    step();
    tests_run++; if (bus_hi.valid !== 1'b0 || bus_hi.pending !== 8'h00 || bus_hi.a !== 3'd0) begin tests_failed++; $display("FAIL mid_reset: got v=%0b p=%0h a=%0d want v=0 p=00 a=0", bus_hi.valid, bus_hi.pending, bus_hi.a); end
    reset_p = 1'b0;
    drive(8'h00, 1'b0);
  endtask

  task automatic test_level_mode();
    do_reset();
    drive(8'h04, 1'b1);
    step();
    tests_run++; if (bus_lv.pending !== 8'h04 || bus_lv.valid !== 1'b0) begin tests_failed++; $display("FAIL lvl_capture: got p=%0h v=%0b want p=04 v=0", bus_lv.pending, bus_lv.valid); end
    step();
    tests_run++; if (bus_lv.valid !== 1'b1 || bus_lv.a !== 3'd2) begin tests_failed++; $display("FAIL lvl_present: got v=%0b a=%0d want v=1 a=2", bus_lv.valid, bus_lv.a); end
    step();
    tests_run++; if (bus_lv.valid !== 1'b0 || bus_lv.pending !== 8'h04 || bus_lv.overrun !== 1'b0) begin tests_failed++; $display("FAIL lvl_rearm: got v=%0b p=%0h o=%0b want v=0 p=04 o=0", bus_lv.valid, bus_lv.pending, bus_lv.overrun); end
    step();
    tests_run++; if (bus_lv.valid !== 1'b1 || bus_lv.a !== 3'd2) begin tests_failed++; $display("FAIL lvl_again: got v=%0b a=%0d want v=1 a=2", bus_lv.valid, bus_lv.a); end
    drive(8'h00, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_p      = 1'b1;
    drive(8'h00, 1'b0);
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_overrun();
    test_set_wins();
    test_reset_mid();
    test_level_mode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
